// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the Kyber polynomial decompression path.
//   Q            : Kyber modulus
//   N            : coefficients per polynomial
//   DMAX         : widest supported compressed field
//   D_*          : the legal compression widths
//   decompress_state_t : controller FSM encoding
//   is_legal_d() : true when a requested width is one the controller supports
// -----------------------------------------------------------------------------
package kyber_pkg;

  localparam int Q    = 3329;
  localparam int N    = 256;
  localparam int DMAX = 11;

  localparam logic [3:0] D_1  = 4'd1;
  localparam logic [3:0] D_4  = 4'd4;
  localparam logic [3:0] D_5  = 4'd5;
  localparam logic [3:0] D_10 = 4'd10;
  localparam logic [3:0] D_11 = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } decompress_state_t;

  function automatic logic is_legal_d(input logic [3:0] d);
    return (d == D_1) || (d == D_4) || (d == D_5) || (d == D_10) || (d == D_11);
  endfunction

endpackage

// File: rtl/decompress_module.sv
// -----------------------------------------------------------------------------
// decompress_module
// Combinational Kyber decompression: result = (Q*x + 2^(d-1)) >> d.
// Ports:
//   x      in  11  compressed field (only the low d bits are meaningful)
//   d      in   4  compression width, 1..11
//   result out 12  decompressed coefficient, 0..Q-1
// -----------------------------------------------------------------------------
module decompress_module
  import kyber_pkg::*;
(
  input  logic [10:0] x,
  input  logic [3:0]  d,
  output logic [11:0] result
);

  logic [23:0] prod;
  logic [23:0] rnd;
  logic [23:0] sum;
  logic [23:0] shifted;

  always_comb begin
    // Q*x < 2^23 for x < 2^11, so 24 bits hold the rounded sum without overflow.
    prod    = 24'(Q) * {13'd0, x};
    rnd     = (d == 4'd0) ? 24'd0 : (24'd1 << 4'(d - 4'd1));
    sum     = prod + rnd;
    shifted = sum >> d;
    result  = shifted[11:0];
  end

endmodule

// File: rtl/decompress_ctrl.sv
// -----------------------------------------------------------------------------
// decompress_ctrl
// Sequences one polynomial decompression: unpacks a LSB-first byte stream of
// d-bit fields into 256 coefficients, decompresses each through
// decompress_module and presents them, registered, on a valid/ready stream.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, d_sel        begin a polynomial with width d_sel (1,4,5,10,11)
//   busy, done, err     status: running, end pulse, illegal-width pulse
//   in_data/in_valid/in_ready        byte input stream
//   coef_out/coef_idx/coef_valid/coef_ready   coefficient output stream
// -----------------------------------------------------------------------------
module decompress_ctrl
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  d_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] coef_out,
  output logic [7:0]  coef_idx,
  output logic        coef_valid,
  input  logic        coef_ready
);

  decompress_state_t state_q, state_d;
  logic [3:0]  d_q, d_d;
  logic [8:0]  bytes_left_q, bytes_left_d;
  logic [8:0]  coefs_left_q, coefs_left_d;
  logic [7:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [11:0] coef_out_q, coef_out_d;
  logic [7:0]  coef_idx_q, coef_idx_d;
  logic        coef_valid_q, coef_valid_d;
  logic        err_q, err_d;

  logic        accept;
  logic        extract;
  logic [10:0] x_mask;
  logic [10:0] x_c;
  logic [23:0] merged;
  logic [11:0] dp_result;

  decompress_module u_dp (
    .x      (x_c),
    .d      (d_q),
    .result (dp_result)
  );

  always_comb begin
    state_d      = state_q;
    d_d          = d_q;
    bytes_left_d = bytes_left_q;
    coefs_left_d = coefs_left_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    bitcnt_d     = bitcnt_q;
    coef_out_d   = coef_out_q;
    coef_idx_d   = coef_idx_q;
    coef_valid_d = coef_valid_q;
    err_d        = 1'b0;

    // Keep at most 16 bits buffered before taking a byte so it always fits in 24.
    in_ready = (state_q == ST_RUN) && (bitcnt_q <= 5'd16) && (bytes_left_q != 9'd0);
    accept   = in_valid && in_ready;
    extract  = (state_q == ST_RUN) && (bitcnt_q >= 5'(d_q)) &&
               (!coef_valid_q || coef_ready);

    x_mask = 11'((12'h001 << d_q) - 12'h001);
    // Extraction only needs bits already buffered, so the pre-append buffer suffices.
    x_c    = buf_q[10:0] & x_mask;

    // The new byte lands above the bits held before this edge, then the shift applies.
    merged = buf_q | (accept ? (24'(in_data) << bitcnt_q) : 24'd0);
    if (accept) begin
      bytes_left_d = bytes_left_q - 9'd1;
    end
    buf_d    = extract ? (merged >> d_q) : merged;
    bitcnt_d = 5'(bitcnt_q + (accept ? 5'd8 : 5'd0) - (extract ? 5'(d_q) : 5'd0));

    if (extract) begin
      coef_out_d   = dp_result;
      coef_idx_d   = idx_q;
      coef_valid_d = 1'b1;
      idx_d        = idx_q + 8'd1;
      coefs_left_d = coefs_left_q - 9'd1;
    end else if (coef_ready) begin
      coef_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_legal_d(d_sel)) begin
            d_d          = d_sel;
            bytes_left_d = {d_sel, 5'd0};
            coefs_left_d = 9'(N);
            idx_d        = 8'd0;
            buf_d        = 24'd0;
            bitcnt_d     = 5'd0;
            state_d      = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // 256*d is a whole number of bytes, so buffer and byte count are empty here.
        if (extract && (coefs_left_q == 9'd1)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!coef_valid_q || coef_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      d_q          <= 4'd0;
      bytes_left_q <= 9'd0;
      coefs_left_q <= 9'd0;
      idx_q        <= 8'd0;
      buf_q        <= 24'd0;
      bitcnt_q     <= 5'd0;
      coef_out_q   <= 12'd0;
      coef_idx_q   <= 8'd0;
      coef_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      bytes_left_q <= bytes_left_d;
      coefs_left_q <= coefs_left_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      bitcnt_q     <= bitcnt_d;
      coef_out_q   <= coef_out_d;
      coef_idx_q   <= coef_idx_d;
      coef_valid_q <= coef_valid_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign coef_out   = coef_out_q;
  assign coef_idx   = coef_idx_q;
  assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_decompress_ctrl.sv
module tb_decompress_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  d_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] coef_out;
  logic [7:0]  coef_idx;
  logic        coef_valid;
  logic        coef_ready;

  always #5 clk = ~clk;

  decompress_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .d_sel      (d_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready)
  );

  typedef struct {
    int idx;
    int val;
  } exp_t;

  typedef struct {
    int         d;
    logic [7:0] first_byte;
    logic [7:0] fill_byte;
    int         e0;
    int         e1;
    int         erest;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] stim_bytes[$];
  vec_t       vecs[5];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte stream: one leading byte then a fill byte, with a few spare bytes
  // offered past the end that must never be taken.
  task automatic build_stream(input int d, input logic [7:0] first_b, input logic [7:0] fill_b);
    stim_bytes.delete();
    stim_bytes.push_back(first_b);
    for (int i = 1; i < 32 * d + 4; i++) stim_bytes.push_back(fill_b);
  endtask

  // Independent golden model: LSB-first unpack then (Q*x + 2^(d-1)) >> d.
  task automatic model_expect(input int d);
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      longint x = 0;
      exp_t   e;
      for (int b = 0; b < d; b++) begin
        int   pos = i * d + b;
        logic [7:0] byt = stim_bytes[pos / 8];
        if (byt[pos % 8]) x = x | (longint'(1) << b);
      end
      e.idx = i;
      e.val = int'((longint'(3329) * x + (longint'(1) << (d - 1))) >> d);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_poly(input int d, input bit throttle, input int abort_after, input bit poke_start);
    int         byte_ptr = 0;
    int         hs = 0;
    int         last_hs_iter = -10;
    bit         prev_stall = 1'b0;
    bit         done_seen = 1'b0;
    bit         err_seen = 1'b0;
    logic [11:0] sv_out = '0;
    logic [7:0]  sv_idx = '0;
    exp_t       e;
    @(negedge clk);
    start = 1'b1;
    d_sel = 4'(d);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int iter = 0; iter < 20000; iter++) begin
      if (poke_start) begin
        start = (iter == 40);
        d_sel = 4'd4;
      end
      in_valid   = (byte_ptr < stim_bytes.size()) && (!throttle || ($urandom_range(0, 3) != 0));
      in_data    = in_valid ? stim_bytes[byte_ptr] : 8'h00;
      coef_ready = !throttle || ($urandom_range(0, 1) == 1);
      if (err) err_seen = 1'b1;
      if (prev_stall) begin
        chk("stall_out", int'(coef_out), int'(sv_out));
        chk("stall_idx", int'(coef_idx), int'(sv_idx));
        chk("stall_valid", int'(coef_valid), 1);
      end
      if (done) begin
        chk("done_latency", iter, last_hs_iter + 1);
        chk("bytes_taken", byte_ptr, 32 * d);
        chk("busy_at_done", int'(busy), 0);
        done_seen = 1'b1;
        break;
      end
      if (in_valid && in_ready) byte_ptr++;
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_coef", int'(coef_idx), -1);
        end else begin
          e = exp_q.pop_front();
          chk("coef_idx", int'(coef_idx), e.idx);
          chk("coef_val", int'(coef_out), e.val);
        end
        hs++;
        last_hs_iter = iter;
      end
      prev_stall = coef_valid && !coef_ready;
      sv_out     = coef_out;
      sv_idx     = coef_idx;
      if (abort_after > 0 && hs >= abort_after) break;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (abort_after == 0) begin
      chk("done_seen", int'(done_seen), 1);
      chk("exp_left", exp_q.size(), 0);
    end
    if (poke_start) chk("err_during_busy", int'(err_seen), 0);
  endtask

  task automatic table_expect(input vec_t v);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.idx = i;
      e.val = (i == 0) ? v.e0 : ((i == 1) ? v.e1 : v.erest);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_done"},       int'(done), 0);
    chk({tag, "_err"},        int'(err), 0);
    chk({tag, "_in_ready"},   int'(in_ready), 0);
    chk({tag, "_coef_valid"}, int'(coef_valid), 0);
    chk({tag, "_coef_out"},   int'(coef_out), 0);
    chk({tag, "_coef_idx"},   int'(coef_idx), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    d_sel      = 4'd0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    coef_ready = 1'b0;

    vecs[0] = '{d: 4,  first_byte: 8'h21, fill_byte: 8'h00, e0: 208,  e1: 416,  erest: 0};
    vecs[1] = '{d: 1,  first_byte: 8'hFF, fill_byte: 8'hFF, e0: 1665, e1: 1665, erest: 1665};
    vecs[2] = '{d: 11, first_byte: 8'hFF, fill_byte: 8'hFF, e0: 3327, e1: 3327, erest: 3327};
    vecs[3] = '{d: 10, first_byte: 8'hFF, fill_byte: 8'hFF, e0: 3326, e1: 3326, erest: 3326};
    vecs[4] = '{d: 5,  first_byte: 8'hFF, fill_byte: 8'hFF, e0: 3225, e1: 3225, erest: 3225};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      build_stream(vecs[v].d, vecs[v].first_byte, vecs[v].fill_byte);
      table_expect(vecs[v]);
      run_poly(vecs[v].d, 1'b0, 0, 1'b0);
      $display("poly d=%0d first=%02h fill=%02h done", vecs[v].d, vecs[v].first_byte, vecs[v].fill_byte);
    end

    // Illegal width: one err pulse, controller stays idle.
    @(negedge clk);
    start = 1'b1;
    d_sel = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_err", int'(err), 1);
    chk("illegal_busy", int'(busy), 0);
    chk("illegal_in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("illegal_err_clear", int'(err), 0);
    $display("illegal d_sel=3 checked");

    // d=10 random data with throttling on both sides and a start pulse while busy.
    stim_bytes.delete();
    for (int i = 0; i < 324; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
    model_expect(10);
    run_poly(10, 1'b1, 0, 1'b1);
    $display("poly d=10 random throttled done");

    // Reset in the middle of a d=5 polynomial.
    build_stream(5, 8'hFF, 8'hFF);
    model_expect(5);
    run_poly(5, 1'b0, 100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    rst = 1'b0;
    exp_q.delete();
    $display("reset after 100 coefficients checked");

    build_stream(5, 8'hFF, 8'hFF);
    table_expect(vecs[4]);
    run_poly(5, 1'b0, 0, 1'b0);
    $display("poly d=5 after abort done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
